// File: rtl/qarma128_tweak_sched.sv
// qarma128_tweak_sched
//   Iterative QARMA-128 tweak-schedule sequencer. A 128-bit tweak T0 is loaded
//   on start, then the round tweaks are streamed over a valid/ready interface:
//   the forward half T0..T_R (T_{i+1} = omega(h(T_i))), followed by the backward
//   half T_R..T0. The backward half is recomputed with the inverse updates, so
//   only one tweak register is kept.
//
// Ports
//   clk, rst   clock, asynchronous active-high reset
//   start      load request, only honoured while idle
//   tweak_in   initial tweak T0
//   busy       high while a sequence is in progress
//   tw_out     current round tweak (the tweak register)
//   tw_valid   tw_out is valid
//   tw_ready   consumer accepts tw_out; a handshake is tw_valid & tw_ready
//   tw_round   index i of tw_out (T_i)
//   tw_dir     0 = forward half, 1 = backward half
//   tw_last    final tweak of the sequence (backward half, i = 0)
//   done       one-cycle pulse after the last handshake
module qarma128_tweak_sched #(
  parameter int ROUNDS = 11,
  parameter int CW     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] tweak_in,
  output logic         busy,
  output logic [127:0] tw_out,
  output logic         tw_valid,
  input  logic         tw_ready,
  output logic [3:0]   tw_round,
  output logic         tw_dir,
  output logic         tw_last,
  output logic         done
);

  localparam int         NCELLS     = 128 / CW;
  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

  // The round counter is 4 bits and the cell layout assumes 16 byte cells.
  generate
    if (ROUNDS < 0 || ROUNDS > 15) begin : g_bad_rounds
      $error("qarma128_tweak_sched: ROUNDS must be in 0..15");
    end
    if (CW != 8) begin : g_bad_cw
      $error("qarma128_tweak_sched: CW must be 8 (16 cells of a 128-bit tweak)");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    BWD
  } state_t;

  state_t       state;
  logic [127:0] tw_reg;
  logic [3:0]   cnt;
  logic [127:0] fwd_next;
  logic [127:0] bwd_next;

  // Cell permutation table: output cell i takes input cell h_idx(i).
  function automatic int h_idx(input int i);
    case (i)
      0:       return 6;
      1:       return 5;
      2:       return 14;
      3:       return 15;
      4:       return 0;
      5:       return 1;
      6:       return 2;
      7:       return 3;
      8:       return 7;
      9:       return 12;
      10:      return 13;
      11:      return 4;
      12:      return 8;
      13:      return 9;
      14:      return 10;
      default: return 11;
    endcase
  endfunction

  function automatic logic is_omega_cell(input int i);
    return (i == 0) || (i == 1) || (i == 3) || (i == 4) ||
           (i == 8) || (i == 11) || (i == 13);
  endfunction

  // Cell k lives at bits [127-CW*k -: CW], i.e. cell 0 is the top byte.
  function automatic logic [127:0] h_perm(input logic [127:0] t);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < NCELLS; i++) begin
      r[127-CW*i -: CW] = t[127-CW*h_idx(i) -: CW];
    end
    return r;
  endfunction

  function automatic logic [127:0] h_inv(input logic [127:0] t);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < NCELLS; i++) begin
      r[127-CW*h_idx(i) -: CW] = t[127-CW*i -: CW];
    end
    return r;
  endfunction

  // omega is a one-bit LFSR step: shift right, new MSB = b0 ^ b2.
  function automatic logic [127:0] omega_layer(input logic [127:0] t);
    logic [127:0]    r;
    logic [CW-1:0]   b;
    r = t;
    for (int i = 0; i < NCELLS; i++) begin
      if (is_omega_cell(i)) begin
        b = t[127-CW*i -: CW];
        r[127-CW*i -: CW] = {b[0] ^ b[2], b[CW-1:1]};
      end
    end
    return r;
  endfunction

  // Inverse LFSR step: shift left, recovered b0 = o7 ^ o1.
  function automatic logic [127:0] omega_inv_layer(input logic [127:0] t);
    logic [127:0]    r;
    logic [CW-1:0]   o;
    r = t;
    for (int i = 0; i < NCELLS; i++) begin
      if (is_omega_cell(i)) begin
        o = t[127-CW*i -: CW];
        r[127-CW*i -: CW] = {o[CW-2:0], o[CW-1] ^ o[1]};
      end
    end
    return r;
  endfunction

  assign fwd_next = omega_layer(h_perm(tw_reg));
  assign bwd_next = h_inv(omega_inv_layer(tw_reg));

  assign tw_out   = tw_reg;
  assign tw_round = cnt;

  // Sequencer. In FWD/BWD tw_valid is always high, so tw_ready alone marks a
  // handshake. The FWD->BWD turn keeps reg/cnt so T_R is emitted twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tw_reg   <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      tw_valid <= 1'b0;
      tw_dir   <= 1'b0;
      tw_last  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FWD;
            tw_reg   <= tweak_in;
            cnt      <= '0;
            busy     <= 1'b1;
            tw_valid <= 1'b1;
            tw_dir   <= 1'b0;
            tw_last  <= 1'b0;
          end
        end
        FWD: begin
          if (tw_ready) begin
            if (cnt == LAST_ROUND) begin
              state   <= BWD;
              tw_dir  <= 1'b1;
              tw_last <= (cnt == 4'd0);
            end else begin
              tw_reg <= fwd_next;
              cnt    <= cnt + 4'd1;
            end
          end
        end
        BWD: begin
          if (tw_ready) begin
            if (cnt == 4'd0) begin
              state    <= IDLE;
              busy     <= 1'b0;
              tw_valid <= 1'b0;
              tw_dir   <= 1'b0;
              tw_last  <= 1'b0;
              done     <= 1'b1;
            end else begin
              tw_reg  <= bwd_next;
              cnt     <= cnt - 4'd1;
              tw_last <= (cnt == 4'd1);
            end
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          tw_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qarma128_tweak_sched.sv
// tb_qarma128_tweak_sched
//   Self-checking bench for qarma128_tweak_sched. Expected tweak sequences come
//   from a byte-array model of h / omega built from the cell tables.
module tb_qarma128_tweak_sched;

  localparam int R = 11;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] tweak_in = '0;
  logic         tw_ready = 1'b0;
  logic         busy;
  logic [127:0] tw_out;
  logic         tw_valid;
  logic [3:0]   tw_round;
  logic         tw_dir;
  logic         tw_last;
  logic         done;

  int checks = 0;
  int errors = 0;

  int HP[16] = '{6, 5, 14, 15, 0, 1, 2, 3, 7, 12, 13, 4, 8, 9, 10, 11};

  logic [127:0] obs_out[$];
  logic [3:0]   obs_round[$];
  logic         obs_dir[$];
  logic         obs_last[$];
  logic [127:0] exp_out[$];
  logic [3:0]   exp_round[$];
  logic         exp_dir[$];
  logic         exp_last[$];

  int stall_viol;
  bit first_valid, timed_out, done_at_end, busy_at_end, valid_at_end;

  qarma128_tweak_sched #(.ROUNDS(R), .CW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .tweak_in(tweak_in),
    .busy(busy), .tw_out(tw_out), .tw_valid(tw_valid), .tw_ready(tw_ready),
    .tw_round(tw_round), .tw_dir(tw_dir), .tw_last(tw_last), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference forward update on an array of 16 byte cells.
  function automatic logic [127:0] model_fwd(input logic [127:0] t);
    byte unsigned c[16];
    byte unsigned d[16];
    logic [127:0] r;
    for (int k = 0; k < 16; k++) c[k] = 8'(t >> (8 * (15 - k)));
    for (int i = 0; i < 16; i++) d[i] = c[HP[i]];
    for (int i = 0; i < 16; i++)
      if (i inside {0, 1, 3, 4, 8, 11, 13})
        d[i] = 8'((d[i] >> 1) | (((d[i] ^ (d[i] >> 2)) & 8'd1) << 7));
    r = '0;
    for (int k = 0; k < 16; k++) r = (r << 8) | 128'(d[k]);
    return r;
  endfunction

  function automatic logic [127:0] model_bwd(input logic [127:0] t);
    byte unsigned c[16];
    byte unsigned d[16];
    logic [127:0] r;
    for (int k = 0; k < 16; k++) c[k] = 8'(t >> (8 * (15 - k)));
    for (int i = 0; i < 16; i++)
      if (i inside {0, 1, 3, 4, 8, 11, 13})
        c[i] = 8'((c[i] << 1) | (((c[i] >> 7) ^ (c[i] >> 1)) & 8'd1));
    for (int i = 0; i < 16; i++) d[HP[i]] = c[i];
    r = '0;
    for (int k = 0; k < 16; k++) r = (r << 8) | 128'(d[k]);
    return r;
  endfunction

  task automatic build_model(input logic [127:0] t0);
    logic [127:0] t;
    exp_out.delete(); exp_round.delete(); exp_dir.delete(); exp_last.delete();
    t = t0;
    for (int i = 0; i <= R; i++) begin
      exp_out.push_back(t); exp_round.push_back(4'(i));
      exp_dir.push_back(1'b0); exp_last.push_back(1'b0);
      if (i < R) t = model_fwd(t);
    end
    for (int i = R; i >= 0; i--) begin
      exp_out.push_back(t); exp_round.push_back(4'(i));
      exp_dir.push_back(1'b1); exp_last.push_back(i == 0);
      t = model_bwd(t);
    end
  endtask

  // Starts a sequence and records every handshake. Returns at the negedge
  // after the last handshake (the cycle where done should be high).
  task automatic collect(input logic [127:0] tw, input int pct,
                         input int inject_at, input logic [127:0] inject_tw);
    logic [127:0] p_out;
    logic [3:0]   p_round;
    logic         p_dir, p_last;
    bit           stalled;
    obs_out.delete(); obs_round.delete(); obs_dir.delete(); obs_last.delete();
    stall_viol = 0; timed_out = 0; stalled = 0;
    done_at_end = 0; busy_at_end = 1; valid_at_end = 1;
    p_out = '0; p_round = '0; p_dir = 0; p_last = 0;
    @(negedge clk);
    tweak_in = tw; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    first_valid = tw_valid;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc == inject_at) begin
        start = 1'b1; tweak_in = inject_tw;
      end else begin
        start = 1'b0;
      end
      if (stalled && (tw_out !== p_out || tw_round !== p_round || tw_dir !== p_dir ||
                      tw_last !== p_last || tw_valid !== 1'b1))
        stall_viol++;
      tw_ready = ($urandom_range(0, 99) < pct);
      if (tw_valid && tw_ready) begin
        obs_out.push_back(tw_out); obs_round.push_back(tw_round);
        obs_dir.push_back(tw_dir); obs_last.push_back(tw_last);
        stalled = 0;
        if (tw_last) begin
          @(negedge clk);
          tw_ready = 1'b0; start = 1'b0;
          done_at_end = done; busy_at_end = busy; valid_at_end = tw_valid;
          return;
        end
      end else begin
        stalled = tw_valid;
        p_out = tw_out; p_round = tw_round; p_dir = tw_dir; p_last = tw_last;
      end
      @(negedge clk);
    end
    timed_out = 1; tw_ready = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    checks++; if (tw_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b, expected 0", tw_valid); end
    checks++; if (tw_out !== 128'd0) begin errors++; $display("[TB] FAIL reset_out: got %h, expected 0", tw_out); end
    checks++; if (tw_round !== 4'd0) begin errors++; $display("[TB] FAIL reset_round: got %0d, expected 0", tw_round); end
    checks++; if (tw_dir !== 1'b0 || tw_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_dir_last: got %b%b, expected 00", tw_dir, tw_last); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b, expected 0", done); end
    rst = 1'b0;
    tw_ready = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || tw_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_reset: busy=%b valid=%b, expected 0 0", busy, tw_valid); end
    tw_ready = 1'b0;
  endtask

  task automatic test_zero_tweak();
    build_model(128'd0);
    collect(128'd0, 100, -1, '0);
    checks++; if (timed_out !== 1'b0 || first_valid !== 1'b1) begin errors++; $display("[TB] FAIL zero_flow: timeout=%b first_valid=%b, expected 0 1", timed_out, first_valid); end
    checks++; if (obs_out.size() !== 2 * R + 2) begin errors++; $display("[TB] FAIL zero_len: got %0d handshakes, expected %0d", obs_out.size(), 2 * R + 2); end
    for (int i = 0; i < exp_out.size() && i < obs_out.size(); i++) begin
      checks++;
      if (obs_out[i] !== exp_out[i] || obs_round[i] !== exp_round[i] || obs_dir[i] !== exp_dir[i] || obs_last[i] !== exp_last[i]) begin
        errors++;
        $display("[TB] FAIL zero_hs%0d: got out=%h rnd=%0d dir=%b last=%b, expected out=%h rnd=%0d dir=%b last=%b",
                 i, obs_out[i], obs_round[i], obs_dir[i], obs_last[i], exp_out[i], exp_round[i], exp_dir[i], exp_last[i]);
      end
    end
    checks++; if (done_at_end !== 1'b1 || busy_at_end !== 1'b0 || valid_at_end !== 1'b0) begin errors++; $display("[TB] FAIL zero_done: done=%b busy=%b valid=%b, expected 1 0 0", done_at_end, busy_at_end, valid_at_end); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL zero_done_pulse: done=%b one cycle later, expected 0", done); end
  endtask

  task automatic test_single_cell();
    logic [127:0] t0;
    t0 = 128'h00000000_01000000_00000000_00000000;
    build_model(t0);
    collect(t0, 100, -1, '0);
    checks++; if (obs_out.size() < 2 || obs_out[1] !== 128'h00000000_00000000_00000080_00000000) begin errors++; $display("[TB] FAIL cell_t1: got %h, expected %h", (obs_out.size() > 1) ? obs_out[1] : 128'd0, 128'h00000000_00000000_00000080_00000000); end
    checks++; if (obs_out.size() !== exp_out.size()) begin errors++; $display("[TB] FAIL cell_len: got %0d, expected %0d", obs_out.size(), exp_out.size()); end
    for (int i = 0; i < exp_out.size() && i < obs_out.size(); i++) begin
      checks++;
      if (obs_out[i] !== exp_out[i] || obs_round[i] !== exp_round[i] || obs_dir[i] !== exp_dir[i] || obs_last[i] !== exp_last[i]) begin
        errors++;
        $display("[TB] FAIL cell_hs%0d: got out=%h rnd=%0d dir=%b last=%b, expected out=%h rnd=%0d dir=%b last=%b",
                 i, obs_out[i], obs_round[i], obs_dir[i], obs_last[i], exp_out[i], exp_round[i], exp_dir[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_random_symmetry();
    logic [127:0] t0;
    for (int n = 0; n < 3; n++) begin
      t0 = rand128();
      build_model(t0);
      collect(t0, 100, -1, '0);
      checks++;
      if (obs_out.size() !== 2 * R + 2 || timed_out) begin
        errors++; $display("[TB] FAIL sym%0d_len: got %0d handshakes, expected %0d", n, obs_out.size(), 2 * R + 2);
      end else begin
        for (int i = 0; i <= R; i++) begin
          checks++;
          if (obs_out[2 * R + 1 - i] !== obs_out[i] || obs_out[i] !== exp_out[i]) begin
            errors++; $display("[TB] FAIL sym%0d_round%0d: fwd=%h bwd=%h, expected both %h", n, i, obs_out[i], obs_out[2 * R + 1 - i], exp_out[i]);
          end
        end
        checks++;
        if (obs_out[2 * R + 1] !== t0) begin errors++; $display("[TB] FAIL sym%0d_last: got %h, expected %h", n, obs_out[2 * R + 1], t0); end
      end
    end
  endtask

  task automatic test_ready_toggle();
    logic [127:0] t0;
    for (int n = 0; n < 2; n++) begin
      t0 = rand128();
      build_model(t0);
      collect(t0, 50, -1, '0);
      checks++; if (stall_viol !== 0 || timed_out) begin errors++; $display("[TB] FAIL toggle%0d_stall: %0d unstable stall cycles (timeout=%b), expected 0", n, stall_viol, timed_out); end
      checks++; if (obs_out.size() !== exp_out.size()) begin errors++; $display("[TB] FAIL toggle%0d_len: got %0d, expected %0d", n, obs_out.size(), exp_out.size()); end
      for (int i = 0; i < exp_out.size() && i < obs_out.size(); i++) begin
        checks++;
        if (obs_out[i] !== exp_out[i] || obs_round[i] !== exp_round[i] || obs_dir[i] !== exp_dir[i] || obs_last[i] !== exp_last[i]) begin
          errors++;
          $display("[TB] FAIL toggle%0d_hs%0d: got out=%h rnd=%0d dir=%b last=%b, expected out=%h rnd=%0d dir=%b last=%b",
                   n, i, obs_out[i], obs_round[i], obs_dir[i], obs_last[i], exp_out[i], exp_round[i], exp_dir[i], exp_last[i]);
        end
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [127:0] t0;
    t0 = rand128();
    build_model(t0);
    collect(t0, 100, 5, ~t0);
    checks++; if (obs_out.size() !== exp_out.size() || done_at_end !== 1'b1) begin errors++; $display("[TB] FAIL busy_start_len: got %0d handshakes done=%b, expected %0d 1", obs_out.size(), done_at_end, exp_out.size()); end
    for (int i = 0; i < exp_out.size() && i < obs_out.size(); i++) begin
      checks++;
      if (obs_out[i] !== exp_out[i] || obs_round[i] !== exp_round[i] || obs_dir[i] !== exp_dir[i]) begin
        errors++;
        $display("[TB] FAIL busy_start_hs%0d: got out=%h rnd=%0d dir=%b, expected out=%h rnd=%0d dir=%b",
                 i, obs_out[i], obs_round[i], obs_dir[i], exp_out[i], exp_round[i], exp_dir[i]);
      end
    end
  endtask

  task automatic test_start_on_done();
    logic [127:0] t0, t1;
    int hs;
    t0 = rand128();
    t1 = rand128();
    collect(t0, 100, -1, '0);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL sod_done: got %b, expected 1", done); end
    start = 1'b1; tweak_in = t1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (tw_valid !== 1'b1 || tw_round !== 4'd0 || tw_dir !== 1'b0 || tw_out !== t1) begin
      errors++; $display("[TB] FAIL sod_restart: valid=%b rnd=%0d dir=%b out=%h, expected 1 0 0 %h", tw_valid, tw_round, tw_dir, tw_out, t1);
    end
    hs = 0;
    tw_ready = 1'b1;
    for (int c = 0; c < 100 && busy; c++) begin
      if (tw_valid) hs++;
      @(negedge clk);
    end
    tw_ready = 1'b0;
    checks++; if (hs !== 2 * R + 2 || busy !== 1'b0 || done !== 1'b1) begin errors++; $display("[TB] FAIL sod_drain: hs=%0d busy=%b done=%b, expected %0d 0 1", hs, busy, done, 2 * R + 2); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] t0;
    bit found, saw_done, saw_busy;
    found = 0; saw_done = 0; saw_busy = 0;
    @(negedge clk);
    tweak_in = rand128(); start = 1'b1;
    @(negedge clk);
    start = 1'b0; tw_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (tw_valid && tw_round == 4'd7 && tw_dir == 1'b0) begin found = 1; break; end
      @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL rmid_reach: round 7 forward seen=%b, expected 1", found); end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || tw_valid !== 1'b0 || tw_out !== 128'd0 || tw_round !== 4'd0 || tw_dir !== 1'b0 || tw_last !== 1'b0 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL rmid_async: busy=%b valid=%b out=%h rnd=%0d dir=%b last=%b done=%b, expected all 0", busy, tw_valid, tw_out, tw_round, tw_dir, tw_last, done);
    end
    @(negedge clk);
    rst = 1'b0; tw_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1;
      if (busy) saw_busy = 1;
    end
    checks++; if (saw_done || saw_busy) begin errors++; $display("[TB] FAIL rmid_quiet: done=%b busy=%b after reset, expected 0 0", saw_done, saw_busy); end
    t0 = rand128();
    build_model(t0);
    collect(t0, 100, -1, '0);
    checks++; if (obs_out.size() !== exp_out.size() || done_at_end !== 1'b1) begin errors++; $display("[TB] FAIL rmid_restart_len: got %0d done=%b, expected %0d 1", obs_out.size(), done_at_end, exp_out.size()); end
    for (int i = 0; i < exp_out.size() && i < obs_out.size(); i++) begin
      checks++;
      if (obs_out[i] !== exp_out[i] || obs_round[i] !== exp_round[i] || obs_dir[i] !== exp_dir[i] || obs_last[i] !== exp_last[i]) begin
        errors++;
        $display("[TB] FAIL rmid_hs%0d: got out=%h rnd=%0d, expected out=%h rnd=%0d", i, obs_out[i], obs_round[i], exp_out[i], exp_round[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_tweak();
    test_single_cell();
    test_random_symmetry();
    test_ready_toggle();
    test_start_while_busy();
    test_start_on_done();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
